// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline PC, valid, stall/flush and forwarding control (optional PIPE_HAZARD_PERF_EN counters)
module pipe_hazard_ctrl #(
  parameter int unsigned     N        = 32,
  parameter int unsigned     RA_W     = 4,
  parameter logic [N-1:0]    RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            imem_ready_i,
  input  logic            dmem_req_i,
  input  logic            dmem_ready_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic            id_use1_i,
  input  logic            id_use2_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic            ex_we_i,
  input  logic            ex_load_i,
  input  logic            ex_taken_i,
  input  logic [N-1:0]    ex_target_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic            mem_we_i,
  input  logic            wb_we_i,
  input  logic            mem_load_i,
  output logic [N-1:0]    pc_o,
  output logic            en_if_id_o,
  output logic            en_id_ex_o,
  output logic            en_ex_mem_o,
  output logic            en_mem_wb_o,
  output logic            v_id_o,
  output logic            v_ex_o,
  output logic            v_mem_o,
  output logic            v_wb_o,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
);

  logic [N-1:0]    pc_q, pc_d;
  logic            v_id_q, v_ex_q, v_mem_q, v_wb_q;
  logic            v_id_d, v_ex_d, v_mem_d, v_wb_d;
  logic [RA_W-1:0] ex_rs1_q, ex_rs2_q, ex_rs1_d, ex_rs2_d;
  logic            ex_use1_q, ex_use2_q, ex_use1_d, ex_use2_d;
  logic            mw, lu, br, iw;

  // Hazard detection and next-state selection; mw > br > lu > imem wait
  always_comb begin
    mw = v_mem_q & dmem_req_i & ~dmem_ready_i;
    lu = v_ex_q & ex_load_i & ex_we_i & v_id_q &
         ((id_use1_i & (ex_rd_i == id_rs1_i)) | (id_use2_i & (ex_rd_i == id_rs2_i)));
    br = v_ex_q & ex_taken_i & ~mw;
    iw = ~imem_ready_i;

    en_if_id_o  = 1'b1;
    en_id_ex_o  = 1'b1;
    en_ex_mem_o = 1'b1;
    en_mem_wb_o = 1'b1;
    pc_d        = pc_q + N'(PC_STEP);
    v_id_d      = 1'b1;
    v_ex_d      = v_id_q;
    v_mem_d     = v_ex_q;
    v_wb_d      = v_mem_q;

    if (mw) begin
      en_if_id_o  = 1'b0;
      en_id_ex_o  = 1'b0;
      en_ex_mem_o = 1'b0;
      pc_d        = pc_q;
      v_id_d      = v_id_q;
      v_ex_d      = v_ex_q;
      v_mem_d     = v_mem_q;
      v_wb_d      = 1'b0;
    end else if (br) begin
      pc_d   = ex_target_i;
      v_id_d = 1'b0;
      v_ex_d = 1'b0;
    end else if (lu) begin
      en_if_id_o = 1'b0;
      pc_d       = pc_q;
      v_id_d     = v_id_q;
      v_ex_d     = 1'b0;
    end else if (iw) begin
      pc_d   = pc_q;
      v_id_d = 1'b0;
    end

    // Operand sources follow the instruction into EX; a bubble carries no uses
    if (mw) begin
      ex_rs1_d  = ex_rs1_q;
      ex_rs2_d  = ex_rs2_q;
      ex_use1_d = ex_use1_q;
      ex_use2_d = ex_use2_q;
    end else begin
      ex_rs1_d  = id_rs1_i;
      ex_rs2_d  = id_rs2_i;
      ex_use1_d = id_use1_i & v_ex_d;
      ex_use2_d = id_use2_i & v_ex_d;
    end
  end

  // Forwarding selects; a load in MEM has no data yet so it never forwards
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (ex_use1_q & v_mem_q & mem_we_i & ~mem_load_i & (mem_rd_i == ex_rs1_q))
      fwd_a_o = 2'b01;
    else if (ex_use1_q & v_wb_q & wb_we_i & (wb_rd_i == ex_rs1_q))
      fwd_a_o = 2'b10;
    if (ex_use2_q & v_mem_q & mem_we_i & ~mem_load_i & (mem_rd_i == ex_rs2_q))
      fwd_b_o = 2'b01;
    else if (ex_use2_q & v_wb_q & wb_we_i & (wb_rd_i == ex_rs2_q))
      fwd_b_o = 2'b10;
  end

  // PC, stage valids and EX operand tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q      <= RESET_PC;
      v_id_q    <= 1'b0;
      v_ex_q    <= 1'b0;
      v_mem_q   <= 1'b0;
      v_wb_q    <= 1'b0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      v_id_q    <= v_id_d;
      v_ex_q    <= v_ex_d;
      v_mem_q   <= v_mem_d;
      v_wb_q    <= v_wb_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_use1_q <= ex_use1_d;
      ex_use2_q <= ex_use2_d;
    end
  end

  assign pc_o    = pc_q;
  assign v_id_o  = v_id_q;
  assign v_ex_o  = v_ex_q;
  assign v_mem_o = v_mem_q;
  assign v_wb_o  = v_wb_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Wrapping stall / flush event counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (mw | lu | (iw & ~br))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (br)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_ready_i, dmem_req_i, dmem_ready_i;
  logic [3:0]  id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i;
  logic        id_use1_i, id_use2_i, ex_we_i, ex_load_i, ex_taken_i;
  logic [31:0] ex_target_i;
  logic        mem_we_i, wb_we_i, mem_load_i;
  logic [31:0] pc_o;
  logic        en_if_id_o, en_id_ex_o, en_ex_mem_o, en_mem_wb_o;
  logic        v_id_o, v_ex_o, v_mem_o, v_wb_o;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  pipe_hazard_ctrl dut (
    .CLK(CLK), .RST(RST),
    .imem_ready_i(imem_ready_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use1_i(id_use1_i), .id_use2_i(id_use2_i),
    .ex_rd_i(ex_rd_i), .ex_we_i(ex_we_i), .ex_load_i(ex_load_i), .ex_taken_i(ex_taken_i),
    .ex_target_i(ex_target_i), .mem_rd_i(mem_rd_i), .wb_rd_i(wb_rd_i),
    .mem_we_i(mem_we_i), .wb_we_i(wb_we_i), .mem_load_i(mem_load_i),
    .pc_o(pc_o), .en_if_id_o(en_if_id_o), .en_id_ex_o(en_id_ex_o),
    .en_ex_mem_o(en_ex_mem_o), .en_mem_wb_o(en_mem_wb_o),
    .v_id_o(v_id_o), .v_ex_o(v_ex_o), .v_mem_o(v_mem_o), .v_wb_o(v_wb_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [3:0]  v;
    logic [3:0]  en;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  function automatic void cmp(string name, int cyc, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
    end
  endfunction

  // Monitor: every cycle with a pending expectation is compared mid-cycle
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("pc", e.cyc, pc_o, e.pc);
      cmp("valid", e.cyc, {28'd0, v_id_o, v_ex_o, v_mem_o, v_wb_o}, {28'd0, e.v});
      cmp("enable", e.cyc, {28'd0, en_if_id_o, en_id_ex_o, en_ex_mem_o, en_mem_wb_o}, {28'd0, e.en});
      cmp("fwd_a", e.cyc, {30'd0, fwd_a_o}, {30'd0, e.fa});
      cmp("fwd_b", e.cyc, {30'd0, fwd_b_o}, {30'd0, e.fb});
      cmp("stall_cnt", e.cyc, stall_cnt_o, e.sc);
      cmp("flush_cnt", e.cyc, flush_cnt_o, e.fc);
    end
  end

  task automatic clr();
    imem_ready_i = 1'b1; dmem_req_i = 1'b0; dmem_ready_i = 1'b1;
    id_rs1_i = '0; id_rs2_i = '0; id_use1_i = 1'b0; id_use2_i = 1'b0;
    ex_rd_i = '0; ex_we_i = 1'b0; ex_load_i = 1'b0; ex_taken_i = 1'b0; ex_target_i = '0;
    mem_rd_i = '0; wb_rd_i = '0; mem_we_i = 1'b0; wb_we_i = 1'b0; mem_load_i = 1'b0;
  endtask

  // Push this cycle's expected outputs, then advance one clock
  task automatic chk(input logic [31:0] pc, input logic [3:0] v, input logic [3:0] en,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    e.cyc = cyc_no; e.pc = pc; e.v = v; e.en = en; e.fa = fa; e.fb = fb;
    e.sc = PERF ? sc : 32'd0;
    e.fc = PERF ? fc : 32'd0;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    cyc_no++;
  endtask

  localparam logic [3:0] ALL = 4'b1111;

  initial begin
    RST = 1'b1;
    clr();
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Straight-line fetch after reset
    for (int i = 0; i < 6; i++) begin
      logic [3:0] v;
      clr();
      case (i)
        0: v = 4'b0000;
        1: v = 4'b1000;
        2: v = 4'b1100;
        3: v = 4'b1110;
        default: v = 4'b1111;
      endcase
      chk(32'(i), v, ALL, 2'b00, 2'b00, 0, 0);
    end

    // Load-use: load in EX writes r3, ID reads r3
    clr(); ex_load_i = 1; ex_we_i = 1; ex_rd_i = 3; id_rs1_i = 3; id_use1_i = 1;
    chk(6, 4'b1111, 4'b0111, 2'b00, 2'b00, 0, 0);
    clr(); id_rs1_i = 3; id_use1_i = 1; mem_rd_i = 3; mem_we_i = 1; mem_load_i = 1;
    chk(6, 4'b1011, ALL, 2'b00, 2'b00, 1, 0);
    // Load now in WB forwards; same cycle EX branch at pc 7 to 0x40
    clr(); wb_rd_i = 3; wb_we_i = 1; ex_taken_i = 1; ex_target_i = 32'h40;
    chk(7, 4'b1101, ALL, 2'b10, 2'b00, 1, 0);
    clr(); chk(32'h40, 4'b0010, ALL, 2'b00, 2'b00, 1, 1);
    clr(); chk(32'h41, 4'b1001, ALL, 2'b00, 2'b00, 1, 1);
    clr(); chk(32'h42, 4'b1100, ALL, 2'b00, 2'b00, 1, 1);

    // Taken branch held back by a 3-cycle data-memory wait
    for (int i = 0; i < 3; i++) begin
      clr(); dmem_req_i = 1; dmem_ready_i = 0; ex_taken_i = 1; ex_target_i = 32'h80;
      chk(32'h43, 4'b1110, 4'b0001, 2'b00, 2'b00, 32'(1 + i), 1);
    end
    clr(); dmem_req_i = 1; dmem_ready_i = 1; ex_taken_i = 1; ex_target_i = 32'h80;
    chk(32'h43, 4'b1110, ALL, 2'b00, 2'b00, 4, 1);

    // Instruction-memory wait
    clr(); imem_ready_i = 0;
    chk(32'h80, 4'b0011, ALL, 2'b00, 2'b00, 4, 2);
    clr(); chk(32'h80, 4'b0001, ALL, 2'b00, 2'b00, 5, 2);

    // Forwarding: ID keeps reading r5 / r6 while the pipe refills
    clr(); id_rs1_i = 5; id_use1_i = 1; id_rs2_i = 6; id_use2_i = 1;
    chk(32'h81, 4'b1000, ALL, 2'b00, 2'b00, 5, 2);
    chk(32'h82, 4'b1100, ALL, 2'b00, 2'b00, 5, 2);
    mem_rd_i = 5; wb_rd_i = 5; wb_we_i = 1;
    chk(32'h83, 4'b1110, ALL, 2'b00, 2'b00, 5, 2);
    mem_we_i = 1;
    chk(32'h84, 4'b1111, ALL, 2'b01, 2'b00, 5, 2);
    mem_load_i = 1;
    chk(32'h85, 4'b1111, ALL, 2'b10, 2'b00, 5, 2);
    mem_load_i = 0; mem_rd_i = 6;
    chk(32'h86, 4'b1111, ALL, 2'b10, 2'b01, 5, 2);

    // Reset asserted during a memory wait
    clr(); dmem_req_i = 1; dmem_ready_i = 0; RST = 1;
    chk(32'h87, 4'b1111, 4'b0001, 2'b00, 2'b00, 5, 2);
    RST = 0; clr();
    chk(0, 4'b0000, ALL, 2'b00, 2'b00, 0, 0);
    chk(1, 4'b1000, ALL, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
